// File: rtl/fbw_pkg.sv
// Shared types and helpers for the framebuffer writer (fb_writer, fbw_packer).
// FBW_RGB888_IN_EN selects 24-bit RGB888 pixel input, truncated to RGB222.
package fbw_pkg;

    localparam int unsigned PIX_W       = 6;
    localparam int unsigned PACK_PIXELS = 4;
    localparam int unsigned PACK_BYTES  = 3;
    localparam int unsigned PACK_W      = PACK_PIXELS * PIX_W;
    localparam int unsigned RGB888_W    = 24;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WR0     = 2'd1,
        WR1     = 2'd2,
        WR2     = 2'd3
    } fbw_state_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // Keep the two MSBs of each 8-bit channel; no rounding.
    function automatic rgb222_t rgb888_to_rgb222(input logic [RGB888_W-1:0] c);
        rgb222_t p;
        p.r = c[23:22];
        p.g = c[15:14];
        p.b = c[7:6];
        return p;
    endfunction

endpackage

// File: rtl/fbw_packer.sv
// Collects PACK_PIXELS pixels into one pack word, pixel 0 in the LSBs.
// pack_full is combinational: high on the load that completes a pack.
module fbw_packer
    import fbw_pkg::*;
#(
    parameter int unsigned PWIDTH = PIX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          clear,
    input  logic [PWIDTH-1:0]             pix,
    output logic [PACK_PIXELS*PWIDTH-1:0] pack,
    output logic                          pack_full
);

    localparam int unsigned PACK_BITS = PACK_PIXELS * PWIDTH;
    localparam int unsigned CNT_W     = $clog2(PACK_PIXELS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PACK_PIXELS - 1);

    logic [CNT_W-1:0] count;

    assign pack_full = load && !clear && (count == LAST_SLOT);

    // A clear that coincides with a load restarts the pack with this pixel as pixel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            pack  <= '0;
        end else if (clear) begin
            if (load) begin
                count <= CNT_W'(1);
                pack  <= PACK_BITS'(pix);
            end else begin
                count <= '0;
                pack  <= '0;
            end
        end else if (load) begin
            for (int s = 0; s < int'(PACK_PIXELS); s++) begin
                if (count == CNT_W'(s)) begin
                    pack[s*PWIDTH +: PWIDTH] <= pix;
                end
            end
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Packs RGB222 pixels 4-to-3 bytes and writes them to the framebuffer with wrapping address.
// FBW_RGB888_IN_EN: PixIn is 24-bit RGB888, truncated to RGB222 before packing.
module fb_writer
    import fbw_pkg::*;
#(
    parameter int unsigned AWIDTH      = 16,
    parameter int unsigned PWIDTH      = PIX_W,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned FRAME_BYTES = 57600
) (
    input  logic                SysClk,
    input  logic                Reset,
`ifdef FBW_RGB888_IN_EN
    input  logic [RGB888_W-1:0] PixIn,
`else
    input  logic [PWIDTH-1:0]   PixIn,
`endif
    input  logic                PixValid,
    output logic                PixReady,
    input  logic                FrameStart,
    output logic [AWIDTH-1:0]   MemAddr,
    output logic [DWIDTH-1:0]   MemData,
    output logic                MemWe,
    input  logic                MemBusy,
    output logic                FrameDone
);

    localparam int unsigned PACK_BITS = PACK_PIXELS * PWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(FRAME_BYTES - 1);

    fbw_state_t              state_q;
    fbw_state_t              state_d;
    logic [AWIDTH-1:0]       addr_d;
    logic [AWIDTH-1:0]       addr_next;
    logic [DWIDTH-1:0]       data_d;
    logic                    we_d;
    logic                    done_d;
    logic                    accept;
    logic                    last_byte;
    logic [PWIDTH-1:0]       pix;
    logic [PACK_BITS-1:0]    pack;
    logic                    pack_full;

`ifdef FBW_RGB888_IN_EN
    assign pix = PWIDTH'(rgb888_to_rgb222(PixIn));
`else
    assign pix = PixIn;
`endif

    // Ready is a decode of the state register, forced low while in reset.
    assign PixReady = (state_q == COLLECT) && !Reset;
    assign accept   = PixValid && PixReady;

    fbw_packer #(
        .PWIDTH (PWIDTH)
    ) u_packer (
        .clk       (SysClk),
        .rst       (Reset),
        .load      (accept),
        .clear     (FrameStart),
        .pix       (pix),
        .pack      (pack),
        .pack_full (pack_full)
    );

    assign last_byte = (MemAddr == LAST_ADDR);
    assign addr_next = last_byte ? '0 : MemAddr + AWIDTH'(1);

    // Next-state and next-output logic; FrameStart overrides everything else.
    always_comb begin
        state_d = state_q;
        addr_d  = MemAddr;
        data_d  = MemData;
        we_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            COLLECT: begin
                if (pack_full) begin
                    state_d = WR0;
                    we_d    = 1'b1;
                    data_d  = pack[0 +: DWIDTH];
                end
            end
            WR0: begin
                we_d = 1'b1;
                if (!MemBusy) begin
                    state_d = WR1;
                    addr_d  = addr_next;
                    data_d  = pack[DWIDTH +: DWIDTH];
                end
            end
            WR1: begin
                we_d = 1'b1;
                if (!MemBusy) begin
                    state_d = WR2;
                    addr_d  = addr_next;
                    data_d  = pack[2*DWIDTH +: DWIDTH];
                end
            end
            WR2: begin
                we_d = 1'b1;
                if (!MemBusy) begin
                    state_d = COLLECT;
                    addr_d  = addr_next;
                    we_d    = 1'b0;
                    done_d  = last_byte;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (FrameStart) begin
            state_d = COLLECT;
            addr_d  = '0;
            we_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and registered memory-interface outputs.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state_q   <= COLLECT;
            MemAddr   <= '0;
            MemData   <= '0;
            MemWe     <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            state_q   <= state_d;
            MemAddr   <= addr_d;
            MemData   <= data_d;
            MemWe     <= we_d;
            FrameDone <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: directed pixel packs, stalls, wrap, FrameStart and reset.
// Built with FBW_RGB888_IN_EN it feeds RGB888 pixels and adds the truncation case.
module tb_fb_writer;
    import fbw_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned FB = 6;
`ifdef FBW_RGB888_IN_EN
    localparam int unsigned PIN_W = 24;
`else
    localparam int unsigned PIN_W = 6;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic             SysClk = 1'b0;
    logic             Reset;
    logic [PIN_W-1:0] PixIn;
    logic             PixValid;
    logic             PixReady;
    logic             FrameStart;
    logic [AW-1:0]    MemAddr;
    logic [DW-1:0]    MemData;
    logic             MemWe;
    logic             MemBusy;
    logic             FrameDone;

    wr_t           exp_q[$];
    int            ncmp = 0;
    int            nerr = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_addr = '0;

    fb_writer #(
        .AWIDTH      (AW),
        .PWIDTH      (6),
        .DWIDTH      (DW),
        .FRAME_BYTES (FB)
    ) dut (
        .SysClk     (SysClk),
        .Reset      (Reset),
        .PixIn      (PixIn),
        .PixValid   (PixValid),
        .PixReady   (PixReady),
        .FrameStart (FrameStart),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .MemWe      (MemWe),
        .MemBusy    (MemBusy),
        .FrameDone  (FrameDone)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    function automatic logic [PIN_W-1:0] pin(input logic [5:0] p);
`ifdef FBW_RGB888_IN_EN
        return {p[5:4], 6'd0, p[3:2], 6'd0, p[1:0], 6'd0};
`else
        return p;
`endif
    endfunction

    // Holds PixValid until the pixel is taken; returns 1 time unit after the accepting edge.
    task automatic send_raw(input logic [PIN_W-1:0] v);
        bit taken = 1'b0;
        PixIn    = v;
        PixValid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge SysClk);
            if (PixReady) taken = 1'b1;
            @(posedge SysClk);
            #1;
        end
        PixValid = 1'b0;
        if (!taken) begin
            ncmp++;
            nerr++;
            $display("FAIL send_timeout: pixel 0x%0h not accepted, required within 50 cycles", v);
        end
    endtask

    task automatic send_pix(input logic [5:0] p);
        send_raw(pin(p));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !PixReady) && n < 200) begin
            @(negedge SysClk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        @(posedge SysClk);
        #1;
    endtask

    task automatic frame_start_pulse();
        FrameStart = 1'b1;
        @(posedge SysClk);
        #1;
        FrameStart = 1'b0;
        chk("fs_addr_zero", MemAddr, 0);
    endtask

    // Monitor: every completed byte is checked against the head of the expected queue.
    always @(negedge SysClk) begin
        if (!Reset && MemWe && !MemBusy) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", MemAddr, MemData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", MemAddr, e.addr);
                chk("wr_data", MemData, e.data);
                last_addr = MemAddr;
            end
        end
        if (FrameDone) begin
            done_cnt++;
            chk("done_after_last_addr", last_addr, FB - 1);
            chk("done_aligned_collect", PixReady, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        int d0;
        Reset      = 1'b1;
        PixIn      = '0;
        PixValid   = 1'b0;
        FrameStart = 1'b0;
        MemBusy    = 1'b0;

        // Reset values
        repeat (2) @(posedge SysClk);
        @(negedge SysClk);
        chk("rst_ready", PixReady, 0);
        chk("rst_we", MemWe, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_data", MemData, 0);
        chk("rst_done", FrameDone, 0);
        @(posedge SysClk);
        #1;
        Reset = 1'b0;
        #1;
        chk("rst_release_ready", PixReady, 1);

        // 1: basic pack, latency and ready-low window
        exp_wr(16'd0, 8'h3F);
        exp_wr(16'd1, 8'h50);
        exp_wr(16'd2, 8'hA9);
        send_pix(6'h3F);
        send_pix(6'h00);
        send_pix(6'h15);
        chk("t1_we_before_4th", MemWe, 0);
        send_pix(6'h2A);
        chk("t1_we_rise", MemWe, 1);
        lo = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge SysClk);
            if (!PixReady) lo++;
        end
        chk("t1_ready_low_cycles", lo, 3);
        drain();

        // 2: 5-cycle stall in WR1
        frame_start_pulse();
        exp_wr(16'd0, 8'h81);
        exp_wr(16'd1, 8'h30);
        exp_wr(16'd2, 8'h10);
        send_pix(6'h01);
        send_pix(6'h02);
        send_pix(6'h03);
        send_pix(6'h04);
        @(posedge SysClk);
        #1;
        MemBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge SysClk);
            chk("t2_stall_addr", MemAddr, 1);
            chk("t2_stall_data", MemData, 8'h30);
            chk("t2_stall_we", MemWe, 1);
            @(posedge SysClk);
            #1;
            if (i == 4) MemBusy = 1'b0;
        end
        chk("t2_next_addr", MemAddr, 2);
        chk("t2_next_data", MemData, 8'h10);
        drain();

        // 3: frame wrap with FRAME_BYTES=6
        frame_start_pulse();
        d0 = done_cnt;
        exp_wr(16'd0, 8'hFF);
        exp_wr(16'd1, 8'hFF);
        exp_wr(16'd2, 8'hFF);
        exp_wr(16'd3, 8'h6A);
        exp_wr(16'd4, 8'hA5);
        exp_wr(16'd5, 8'h56);
        exp_wr(16'd0, 8'h55);
        exp_wr(16'd1, 8'h55);
        exp_wr(16'd2, 8'h55);
        for (int i = 0; i < 4; i++) send_pix(6'h3F);
        send_pix(6'h2A);
        send_pix(6'h15);
        send_pix(6'h2A);
        send_pix(6'h15);
        for (int i = 0; i < 4; i++) send_pix(6'h15);
        drain();
        chk("t3_done_pulses", done_cnt, d0 + 1);

        // 4: FrameStart after 2 pixels, with a pixel in the same cycle
        d0 = done_cnt;
        send_pix(6'h3F);
        send_pix(6'h3F);
        exp_wr(16'd0, 8'h81);
        exp_wr(16'd1, 8'h30);
        exp_wr(16'd2, 8'h10);
        FrameStart = 1'b1;
        send_pix(6'h01);
        FrameStart = 1'b0;
        send_pix(6'h02);
        send_pix(6'h03);
        send_pix(6'h04);
        drain();

        // 4b: FrameStart aborts a stalled write
        for (int i = 0; i < 4; i++) send_pix(6'h3F);
        MemBusy    = 1'b1;
        FrameStart = 1'b1;
        @(posedge SysClk);
        #1;
        FrameStart = 1'b0;
        MemBusy    = 1'b0;
        chk("t4_abort_we", MemWe, 0);
        chk("t4_abort_addr", MemAddr, 0);
        chk("t4_abort_ready", PixReady, 1);
        drain();
        chk("t4_no_done", done_cnt, d0);

        // 5: Reset during WR1
        exp_wr(16'd0, 8'h81);
        send_pix(6'h01);
        send_pix(6'h02);
        send_pix(6'h03);
        send_pix(6'h04);
        @(posedge SysClk);
        #1;
        chk("t5_in_wr1_addr", MemAddr, 1);
        Reset = 1'b1;
        #1;
        chk("t5_rst_we", MemWe, 0);
        chk("t5_rst_addr", MemAddr, 0);
        chk("t5_rst_ready", PixReady, 0);
        @(posedge SysClk);
        @(posedge SysClk);
        #1;
        chk("t5_rst_ready_held", PixReady, 0);
        Reset = 1'b0;
        #1;
        chk("t5_release_ready", PixReady, 1);
        exp_wr(16'd0, 8'h3F);
        exp_wr(16'd1, 8'h50);
        exp_wr(16'd2, 8'hA9);
        send_pix(6'h3F);
        send_pix(6'h00);
        send_pix(6'h15);
        send_pix(6'h2A);
        drain();

`ifdef FBW_RGB888_IN_EN
        // 6: RGB888 truncation
        exp_wr(16'd3, 8'h79);
        exp_wr(16'd4, 8'h9E);
        exp_wr(16'd5, 8'hE7);
        for (int i = 0; i < 4; i++) send_raw(24'hC08040);
        drain();
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side counterpart of the video read-address generator; fills the packed framebuffer that the scan-out path reads.
- Accepts a stream of RGB222 pixels over a valid/ready handshake and packs 4 pixels into 24 bits.
- Writes each pack as 3 consecutive bytes, matching the read side's +3 address step per 4-pixel pack.
- Owns the write address; wraps it at the frame boundary.

Parameters:
AWIDTH, 16, byte-address width
PWIDTH, 6, bits per pixel (RGB222)
DWIDTH, 8, memory data width
FRAME_BYTES, 57600, bytes per frame (320x240 / 4 * 3); last address is FRAME_BYTES-1

Ports:
SysClk  in  1  write-side clock
Reset  in  1  asynchronous, active-high reset
PixIn  in  PWIDTH  pixel data, {R[1:0],G[1:0],B[1:0]}
PixValid  in  1  PixIn is valid
PixReady  out  1  block accepts PixIn this cycle
FrameStart  in  1  single-cycle pulse: restart the frame at address 0
MemAddr  out  AWIDTH  byte write address
MemData  out  DWIDTH  byte write data
MemWe  out  1  write strobe
MemBusy  in  1  memory stall; write completes only when MemBusy=0
FrameDone  out  1  one-cycle pulse after the last byte of the frame is written

Behaviour:
- Reset values: state COLLECT, pixel count 0, pack register 0, MemAddr 0, MemData 0, MemWe 0, FrameDone 0. PixReady is 0 while Reset is high and 1 afterwards.
- FSM states are COLLECT, WR0, WR1, WR2.
- COLLECT:
  - PixReady=1.
  - A pixel is accepted when PixValid and PixReady are both 1.
  - Pixel k (k = 0..3) is stored in pack[6k+5:6k], so pixel 0 occupies the LSBs.
  - Acceptance of the 4th pixel moves the FSM to WR0.
- WRn (n = 0..2):
  - PixReady=0, MemWe=1, MemData=pack[8n+7:8n], MemAddr = current address. All outputs are registered.
  - A byte completes on a cycle with MemWe=1 and MemBusy=0. On completion the address increments and the FSM moves to WR(n+1); after WR2 it returns to COLLECT.
  - While MemBusy=1, the FSM holds with MemAddr, MemData and MemWe stable.
- Latency: MemWe rises the cycle after the 4th pixel is accepted. With no stalls a pack takes 7 cycles (4 collect + 3 write).
- Wrap-around: completion of the byte at FRAME_BYTES-1 sets the address to 0 and pulses FrameDone for one cycle, aligned with the first cycle in COLLECT.
- FrameStart (synchronous, highest priority):
  - Discards any partial pack and aborts an in-flight write; MemWe=0 on the next cycle.
  - Sets address to 0 and state to COLLECT; no FrameDone pulse.
  - A pixel with PixValid=1 in the same cycle as FrameStart is accepted as pixel 0 of the new frame.
- Reset asserted mid-write forces MemWe=0 immediately (asynchronous). The partial pack is lost.
- Address arithmetic is unsigned AWIDTH bits. FRAME_BYTES must be a multiple of 3 and at most 2^AWIDTH.

Optional Feature:
Macro FBW_RGB888_IN_EN.
- Defined: PixIn is 24 bits {R8,G8,B8}. The block stores {R[7:6],G[7:6],B[7:6]} (truncation, no rounding). All other behaviour is identical.
- Undefined: PixIn is PWIDTH bits of native RGB222.

Decomposition:
- Package fbw_pkg:
  - Constants PACK_PIXELS=4 and PACK_BYTES=3; pack width = PACK_PIXELS*PWIDTH = 24.
  - FSM state enum (COLLECT, WR0, WR1, WR2).
  - RGB888-to-RGB222 truncation function.
- One sub-module, fbw_packer: pixel counter plus 24-bit pack register, with load-enable and clear inputs, and a pack_full output.
- The top level holds the FSM, address counter and memory interface.

Test Plan:
1. Pixels 0x3F,0x00,0x15,0x2A with no stall -> writes (0,0x3F),(1,0x50),(2,0xA9); MemWe first rises the cycle after the 4th accept; PixReady low for exactly 3 cycles.
2. MemBusy=1 for 5 cycles during WR1 -> MemAddr=1 and MemData held stable for 6 cycles; write completes on the cycle MemBusy drops; next byte at address 2.
3. FRAME_BYTES=6, 8 pixels -> bytes to addresses 0..5; FrameDone pulses once after address 5; the next pack writes at address 0.
4. FrameStart after 2 pixels, with PixValid=1 and pixel 0x01 in the same cycle -> partial pack dropped; 0x01 becomes pixel 0; the next pack's first write goes to address 0.
5. Reset pulsed while in WR1 -> MemWe=0 immediately, MemAddr=0 and PixReady=0 during reset; after release, PixReady=1 and the next pack writes at address 0.
6. With FBW_RGB888_IN_EN, input 0xC0_80_40 x4 -> stored pixel 0x39; bytes 0x79,0x9E,0xE7.
